// File: rtl/pc_sequencer.sv
// Fetch-address sequencer: sequential advance, one-cycle redirects, and a pending-redirect
// slot that holds a target captured while the pipeline is stalled.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        br_valid,
    input  logic [31:0] br_target,
    input  logic        jr_valid,
    input  logic [31:0] jr_target,
    output logic [31:0] pc,
    output logic [31:0] pc4,
    output logic        fetch_valid,
    output logic        pend
);

    typedef enum logic [1:0] {StRun, StHold, StHoldPend} state_e;

    state_e      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_pend_tgt;
    logic        r_run;

    logic        w_redirect;
    logic [31:0] w_target;
    logic [31:0] w_pc4;

    assign w_redirect = jr_valid | br_valid;
    // jr has priority; targets are always word aligned
    assign w_target   = (jr_valid ? jr_target : br_target) & 32'hFFFF_FFFC;
    assign w_pc4      = r_pc + 32'd4;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= StRun;
            r_pc       <= RESET_PC;
            r_pend_tgt <= 32'h0;
            r_run      <= 1'b0;
        end else begin
            r_run <= 1'b1;
            if (stall) begin
                if (w_redirect) begin
                    r_pend_tgt <= w_target;
                    r_state    <= StHoldPend;
                end else if (r_state == StRun) begin
                    r_state <= StHold;
                end
            end else begin
                // A fresh redirect beats a pending one; otherwise drain the pending slot
                if (w_redirect) begin
                    r_pc <= w_target;
                end else if (r_state == StHoldPend) begin
                    r_pc <= r_pend_tgt;
                end else begin
                    r_pc <= w_pc4;
                end
                r_pend_tgt <= 32'h0;
                r_state    <= StRun;
            end
        end
    end

    assign pc          = r_pc;
    assign pc4         = w_pc4;
    assign pend        = (r_state == StHoldPend);
    assign fetch_valid = r_run & ~stall;

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: reset  input  1  synchronous, active-high; sampled on rising clk edge only.
REQ-003 SHALL have port: stall  input  1  hazard-unit freeze request; PC holds while high.
REQ-004 SHALL have port: br_valid  input  1  branch/j/jal redirect request from D stage.
REQ-005 SHALL have port: br_target  input  32  branch/j/jal target address.
REQ-006 SHALL have port: jr_valid  input  1  jr/jalr redirect request from D stage.
REQ-007 SHALL have port: jr_target  input  32  register-sourced target address.
REQ-008 SHALL have port: pc  output  32  current fetch address, registered.
REQ-009 SHALL have port: pc4  output  32  pc + 4, combinational, modulo 2^32.
REQ-010 SHALL have port: fetch_valid  output  1  instruction at pc is to be fetched this cycle.
REQ-011 SHALL have port: pend  output  1  a redirect is captured and waiting for stall release.
REQ-012 SHALL have parameter: RESET_PC, default 32'h0000_3000, PC value after reset.

Function
REQ-013 SHALL implement three states: RUN, HOLD, HOLD_PEND; encoding free.
REQ-014 SHALL define redirect = jr_valid | br_valid; target = jr_target if jr_valid else br_target (jr wins when both high).
REQ-015 SHALL force target bits [1:0] to 2'b00 before use; upper 30 bits used unchanged.
REQ-016 RUN, stall=0, redirect=0: pc <= pc4 next edge; stay RUN.
REQ-017 RUN, stall=0, redirect=1: pc <= target next edge; stay RUN.
REQ-018 RUN, stall=1, redirect=0: pc holds; -> HOLD.
REQ-019 RUN, stall=1, redirect=1: pc holds; target captured in pending register; -> HOLD_PEND.
REQ-020 HOLD, stall=1: pc holds; redirect=1 captures target, -> HOLD_PEND; else stay HOLD.
REQ-021 HOLD, stall=0: behaves exactly as RUN with stall=0 (REQ-016/017); -> RUN.
REQ-022 HOLD_PEND, stall=1: pc holds; redirect=1 overwrites pending register with new target; stay HOLD_PEND.
REQ-023 HOLD_PEND, stall=0, redirect=0: pc <= pending target; pending cleared; -> RUN.
REQ-024 HOLD_PEND, stall=0, redirect=1: pc <= new target (newer request wins); pending cleared; -> RUN.
REQ-025 pend SHALL be 1 exactly when state is HOLD_PEND.
REQ-026 Redirect latency SHALL be one cycle: target appears on pc the edge after the (unstalled) request cycle.
REQ-027 pc4 at pc=32'hFFFF_FFFC SHALL be 32'h0000_0000; sequential advance wraps accordingly.
REQ-028 fetch_valid SHALL equal run_q & ~stall, where run_q is a register cleared by reset and set at the first non-reset edge.
REQ-029 pc SHALL never change on an edge where stall=1 and reset=0.

Reset
REQ-030 reset=1 at an edge SHALL set pc=RESET_PC, state=RUN, pending register=0, pend=0, run_q=0, regardless of stall or redirect inputs.
REQ-031 Reset asserted mid-HOLD_PEND SHALL discard the pending target; first fetch after reset is RESET_PC.
REQ-032 Asynchronous reset behaviour SHALL NOT exist; reset pulses between edges have no effect.

Verification
REQ-033 Reset, then 3 idle cycles -> pc sequence 0x3000, 0x3004, 0x3008, 0x300C; fetch_valid 0 in first post-reset cycle, then 1.
REQ-034 At pc=0x3008 br_valid=1, br_target=0x3100 -> next pc=0x3100; br_target=0x3103 -> next pc=0x3100.
REQ-035 stall=1 for 3 cycles at pc=0x3010 with br_valid=1 (target 0x3200) in 2nd stalled cycle -> pc stays 0x3010, pend=1 from next cycle, fetch_valid=0; stall drops -> pc=0x3200 next edge, pend=0.
REQ-036 HOLD_PEND with pending 0x3200, stall drops while jr_valid=1, jr_target=0x3400, br_valid=1 -> pc=0x3400, pend=0.
REQ-037 pc=0xFFFF_FFFC, no stall/redirect -> next pc=0x0000_0000, pc4=0x0000_0004.
REQ-038 reset=1 during HOLD_PEND with stall=1 -> pc=0x3000, pend=0; release reset and stall -> pc=0x3004 next cycle.
